// File: rtl/seq_mag_compare.sv
// Multi-cycle magnitude comparator: scans both operands MSB-first, DIGIT bits per cycle,
// behind a start/ready handshake, and reports registered gt/eq/lt/gtet with a done pulse.
module seq_mag_compare #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             a_gtet_b
);

    localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int PW   = NDIG * DIGIT;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             smode_q, smode_d;
    logic [PW-1:0]    ap_q, ap_d;
    logic [PW-1:0]    bp_q, bp_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             primed_q, primed_d;
    logic             decided_q, decided_d;
    logic             dgt_q, dgt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic [PW-1:0]    a_ext, b_ext;
    logic [DIGIT-1:0] dig_a, dig_b;
    logic             dig_diff, dig_gt;
    logic             fin_dec, fin_gt;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        a_ext            = '0;
        b_ext            = '0;
        a_ext[WIDTH-1:0] = a_q;
        b_ext[WIDTH-1:0] = b_q;
        if (smode_q) begin
            a_ext[WIDTH-1] = ~a_q[WIDTH-1];
            b_ext[WIDTH-1] = ~b_q[WIDTH-1];
        end
    end

    // Working operands shift left each step, so the digit under test is always on top.
    assign dig_a    = ap_q[PW-1 -: DIGIT];
    assign dig_b    = bp_q[PW-1 -: DIGIT];
    assign dig_diff = (dig_a != dig_b);
    assign dig_gt   = (dig_a > dig_b);
    assign fin_dec  = decided_q | dig_diff;
    assign fin_gt   = decided_q ? dgt_q : dig_gt;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        smode_d   = smode_q;
        ap_d      = ap_q;
        bp_d      = bp_q;
        idx_d     = idx_q;
        primed_d  = primed_q;
        decided_d = decided_q;
        dgt_d     = dgt_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    smode_d   = signed_mode;
                    idx_d     = IW'(NDIG - 1);
                    primed_d  = 1'b0;
                    decided_d = 1'b0;
                    dgt_d     = 1'b0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!primed_q) begin
                    // First scan cycle loads the sign-adjusted, padded working copies.
                    ap_d     = a_ext;
                    bp_d     = b_ext;
                    primed_d = 1'b1;
                end else if ((EARLY_EXIT != 0) && dig_diff) begin
                    gt_d    = dig_gt;
                    lt_d    = ~dig_gt;
                    eq_d    = 1'b0;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    gt_d    = fin_dec & fin_gt;
                    lt_d    = fin_dec & ~fin_gt;
                    eq_d    = ~fin_dec;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                    ap_d  = ap_q << DIGIT;
                    bp_d  = bp_q << DIGIT;
                    if (dig_diff && !decided_q) begin
                        decided_d = 1'b1;
                        dgt_d     = dig_gt;
                    end
                end
            end
            S_DONE: begin
                primed_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            smode_q   <= 1'b0;
            ap_q      <= '0;
            bp_q      <= '0;
            idx_q     <= '0;
            primed_q  <= 1'b0;
            decided_q <= 1'b0;
            dgt_q     <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            smode_q   <= smode_d;
            ap_q      <= ap_d;
            bp_q      <= bp_d;
            idx_q     <= idx_d;
            primed_q  <= primed_d;
            decided_q <= decided_d;
            dgt_q     <= dgt_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign a_gt_b   = gt_q;
    assign a_eq_b   = eq_q;
    assign a_lt_b   = lt_q;
    assign a_gtet_b = gt_q | eq_q;

endmodule

// File: tb/tb_seq_mag_compare.sv
// Bench for seq_mag_compare: three configurations driven in lockstep and checked against
// an arithmetic reference model for relation, latency and done-pulse shape.
module tb_seq_mag_compare;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       signed_mode;
    logic [7:0] a8_i, b8_i;
    logic [8:0] a9_i, b9_i;

    logic rdy [3];
    logic dn  [3];
    logic gt  [3];
    logic eq  [3];
    logic lt  [3];
    logic ge  [3];

    int n_checks = 0;
    int n_errors = 0;
    int txn_id   = 0;

    always #5 clk = ~clk;

    seq_mag_compare #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a8_i), .b(b8_i), .ready(rdy[0]), .done(dn[0]),
        .a_gt_b(gt[0]), .a_eq_b(eq[0]), .a_lt_b(lt[0]), .a_gtet_b(ge[0])
    );

    seq_mag_compare #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u_full (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a8_i), .b(b8_i), .ready(rdy[1]), .done(dn[1]),
        .a_gt_b(gt[1]), .a_eq_b(eq[1]), .a_lt_b(lt[1]), .a_gtet_b(ge[1])
    );

    seq_mag_compare #(.WIDTH(9), .DIGIT(4), .EARLY_EXIT(1)) u_pad (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a9_i), .b(b9_i), .ready(rdy[2]), .done(dn[2]),
        .a_gt_b(gt[2]), .a_eq_b(eq[2]), .a_lt_b(lt[2]), .a_gtet_b(ge[2])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Result code packs {gt,eq,lt,gtet}: 9 = greater, 5 = equal, 2 = less.
    function automatic void model(input int w, input int dg, input int ee, input bit sm,
                                  input int a_in, input int b_in, output int res, output int k);
        int av, bv, sa, sb, fa, fb, nd, mask;
        av = a_in & ((1 << w) - 1);
        bv = b_in & ((1 << w) - 1);
        sa = av;
        sb = bv;
        if (sm) begin
            if (av >= (1 << (w - 1))) sa = av - (1 << w);
            if (bv >= (1 << (w - 1))) sb = bv - (1 << w);
        end
        res  = (sa > sb) ? 9 : ((sa == sb) ? 5 : 2);
        fa   = sm ? (av ^ (1 << (w - 1))) : av;
        fb   = sm ? (bv ^ (1 << (w - 1))) : bv;
        nd   = (w + dg - 1) / dg;
        mask = (1 << dg) - 1;
        k    = nd;
        if (ee != 0) begin
            for (int i = nd - 1; i >= 0; i--) begin
                if (((fa >> (i * dg)) & mask) != ((fb >> (i * dg)) & mask)) begin
                    k = nd - i;
                    break;
                end
            end
        end
    endfunction

    task automatic run_txn(input bit sm, input int a8v, input int b8v,
                           input int a9v, input int b9v, input bit pulse);
        int d[3];
        int np[3];
        int res[3];
        int er, ek, c;
        int wd[3] = '{8, 8, 9};
        int dg[3] = '{2, 2, 4};
        int ee[3] = '{1, 0, 1};
        for (int i = 0; i < 3; i++) begin
            d[i] = 0; np[i] = 0; res[i] = 0;
        end
        c = 0;
        while (!(rdy[0] && rdy[1] && rdy[2]) && c < 20) begin
            @(posedge clk); #1; c++;
        end
        check("ready_before_start", int'(rdy[0] && rdy[1] && rdy[2]), 1);

        @(negedge clk);
        signed_mode = sm;
        a8_i = 8'(a8v); b8_i = 8'(b8v);
        a9_i = 9'(a9v); b9_i = 9'(b9v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (pulse) begin
            // A second request during the scan must be dropped entirely.
            start = 1'b1;
            signed_mode = ~sm;
            a8_i = ~a8_i; b8_i = 8'($urandom);
            a9_i = ~a9_i; b9_i = 9'($urandom);
        end
        for (c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            a8_i = 8'($urandom); b8_i = 8'($urandom);
            a9_i = 9'($urandom); b9_i = 9'($urandom);
            for (int i = 0; i < 3; i++) begin
                if (dn[i]) begin
                    np[i]++;
                    if (d[i] == 0) begin
                        d[i]   = c;
                        res[i] = {28'd0, gt[i], eq[i], lt[i], ge[i]};
                    end
                end
            end
        end
        txn_id++;
        for (int i = 0; i < 3; i++) begin
            model(wd[i], dg[i], ee[i], sm, (i == 2) ? a9v : a8v, (i == 2) ? b9v : b8v, er, ek);
            check($sformatf("dut%0d_latency", i), d[i], ek + 1);
            check($sformatf("dut%0d_result", i), res[i], er);
            check($sformatf("dut%0d_done_pulses", i), np[i], 1);
            check($sformatf("dut%0d_result_hold", i), int'({gt[i], eq[i], lt[i], ge[i]}), er);
        end
        $display("txn %0d sm=%0d a8=%02h b8=%02h a9=%03h b9=%03h pulse=%0d lat=%0d/%0d/%0d res=%0d/%0d/%0d",
                 txn_id, sm, a8v & 8'hFF, b8v & 8'hFF, a9v & 9'h1FF, b9v & 9'h1FF, pulse,
                 d[0], d[1], d[2], res[0], res[1], res[2]);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0;
        a8_i = '0; b8_i = '0; a9_i = '0; b9_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d_reset_ready", i), int'(rdy[i]), 1);
            check($sformatf("dut%0d_reset_outs", i), int'({dn[i], gt[i], eq[i], lt[i], ge[i]}), 0);
        end

        run_txn(1'b0, 8'hA5, 8'h5A, 9'h100, 9'h0FF, 1'b0);
        run_txn(1'b0, 8'h3C, 8'h3C, 9'h03C, 9'h03C, 1'b0);
        run_txn(1'b1, 8'h80, 8'h01, 9'h100, 9'h0FF, 1'b0);
        run_txn(1'b0, 8'h80, 8'h01, 9'h0FF, 9'h100, 1'b0);
        run_txn(1'b1, 8'h7F, 8'h80, 9'h0FF, 9'h100, 1'b0);
        run_txn(1'b1, 8'hFF, 8'hFF, 9'h1FF, 9'h000, 1'b0);
        run_txn(1'b0, 8'h00, 8'h01, 9'h000, 9'h001, 1'b1);
        run_txn(1'b0, 8'hA5, 8'h5A, 9'h100, 9'h0FF, 1'b1);

        for (int t = 0; t < 40; t++) begin
            int ra, rb;
            ra = int'($urandom_range(0, 511));
            rb = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 511));
            run_txn(1'(($urandom) & 1), ra & 8'hFF, rb & 8'hFF, ra, rb, 1'(($urandom_range(0, 4) == 0)));
        end

        // Reset during a scan: no done pulse and results cleared.
        run_txn(1'b0, 8'hF0, 8'h0F, 9'h1F0, 9'h00F, 1'b0);
        @(negedge clk);
        signed_mode = 1'b0; a8_i = 8'h11; b8_i = 8'h11; a9_i = 9'h011; b9_i = 9'h011;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("dut%0d_abort_outs", i), int'({dn[i], gt[i], eq[i], lt[i], ge[i]}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("dut%0d_abort_ready", i), int'(rdy[i]), 1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (dn[i]) seen++;
        end
        check("abort_no_done", seen, 0);
        $display("txn %0d reset-abort done_seen=%0d", txn_id + 1, seen);

        run_txn(1'b1, 8'h01, 8'hFE, 9'h001, 9'h1FE, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
